// File: rtl/riscv_pkg.sv
// riscv_pkg: shared MEM-stage FSM states and D-cache word-address width
package riscv_pkg;
  localparam int DC_AW = 30;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} mem_state_t;
endpackage

// File: rtl/mem_fsm.sv
// mem_fsm: D-cache request sequencing, miss stall and post-completion hold
module mem_fsm
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic memrd,
  input  logic memwr,
  input  logic mis,
  input  logic dc_stall,
  input  logic stall_in,
  output logic ren,
  output logic wen,
  output logic mem_stall,
  output logic done,
  output logic hold
);
  mem_state_t state, state_nx;
  logic req;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // Request is live in IDLE and BUSY alike; upstream is frozen during a miss so inputs stay stable.
  always_comb begin
    req = rst_n & (state != HOLD) & (memrd | memwr) & ~mis;
    ren = req & memrd;
    wen = req & memwr & ~memrd;
    mem_stall = (ren | wen) & dc_stall;
    done = (ren | wen) & ~dc_stall;
    hold = state == HOLD;
    state_nx = mem_stall ? BUSY : (((done | hold) & stall_in) ? HOLD : IDLE);
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with D-cache interface and MEM/WB registers.
// Optional MEM_MISALIGN_CHECK_EN adds misalign_err and suppresses unaligned accesses.
module mem_stage
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      alu_result_in,
  input  logic [31:0]      mem_wdata_in,
  input  logic [4:0]       rd_in,
  input  logic [31:0]      PC_step_in,
  input  logic             memrd_in,
  input  logic             memwr_in,
  input  logic             mem2reg_in,
  input  logic             regwr_in,
  input  logic             jump_in,
  input  logic             mul_ppl_in,
  input  logic             stall_in,
  output logic             mem_stall,
  output logic             DCACHE_ren,
  output logic             DCACHE_wen,
  output logic [DC_AW-1:0] DCACHE_addr,
  output logic [31:0]      DCACHE_wdata,
  input  logic [31:0]      DCACHE_rdata,
  input  logic             DCACHE_stall,
  output logic [31:0]      wb_data,
  output logic [4:0]       rd_out,
  output logic             regwr_out,
  output logic             mul_ppl_out,
  output logic [31:0]      fwd_mem_dat,
  output logic [4:0]       fwd_mem_rd,
  output logic             fwd_mem_regwr
`ifdef MEM_MISALIGN_CHECK_EN
  ,output logic            misalign_err
`endif
);
  logic mis, done, hold, advance;
  logic [31:0] load_q, load_data, sel;
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = (memrd_in | memwr_in) & |alu_result_in[1:0];
  always_ff @(posedge clk) misalign_err <= rst_n & (misalign_err | mis);
`else
  assign mis = 1'b0;
`endif
  mem_fsm u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .memrd    (memrd_in),
    .memwr    (memwr_in),
    .mis      (mis),
    .dc_stall (DCACHE_stall),
    .stall_in (stall_in),
    .ren      (DCACHE_ren),
    .wen      (DCACHE_wen),
    .mem_stall(mem_stall),
    .done     (done),
    .hold     (hold)
  );
  assign DCACHE_addr = alu_result_in[31:2];
  assign DCACHE_wdata = mem_wdata_in;
  assign load_data = hold ? load_q : DCACHE_rdata;
  assign fwd_mem_dat = jump_in ? PC_step_in : alu_result_in;
  assign fwd_mem_rd = rd_in;
  assign fwd_mem_regwr = regwr_in & ~mem2reg_in;
  assign sel = mem2reg_in ? load_data : fwd_mem_dat;
  assign advance = ~mem_stall & ~stall_in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q <= '0;
      wb_data <= '0;
      rd_out <= '0;
      regwr_out <= 1'b0;
      mul_ppl_out <= 1'b0;
    end else begin
      if (done & stall_in) load_q <= DCACHE_rdata;
      if (advance) begin
        wb_data <= sel;
        rd_out <= rd_in;
        regwr_out <= regwr_in & ~mis;
        mul_ppl_out <= mul_ppl_in;
      end
    end
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  synchronous active-low reset (one clock; reset synchronous, active-low).
REQ-002 SHALL accept EX/MEM inputs: alu_result_in 32, mem_wdata_in 32, rd_in 5, PC_step_in 32, memrd_in 1, memwr_in 1, mem2reg_in 1, regwr_in 1, jump_in 1, mul_ppl_in 1.
REQ-003 SHALL have stall_in  in  1  (external hold, e.g. I-cache/mul) and mem_stall  out  1  (this stage busy; to hazard unit, holds all upstream stages).
REQ-004 SHALL drive D-cache: DCACHE_ren out 1, DCACHE_wen out 1, DCACHE_addr out 30 (word address), DCACHE_wdata out 32; and take DCACHE_rdata in 32, DCACHE_stall in 1.
REQ-005 SHALL output MEM/WB: wb_data 32, rd_out 5, regwr_out 1, mul_ppl_out 1.
REQ-006 SHALL output forwarding: fwd_mem_dat 32, fwd_mem_rd 5, fwd_mem_regwr 1 (combinational, current EX/MEM contents).

Function
REQ-007 DCACHE_addr SHALL equal alu_result_in[31:2]; DCACHE_wdata SHALL equal mem_wdata_in.
REQ-008 FSM states SHALL be IDLE, BUSY, HOLD; encoding 2 bits.
REQ-009 IDLE: memrd_in|memwr_in SHALL assert DCACHE_ren/DCACHE_wen same cycle; if DCACHE_stall=0 access completes that cycle (hit); if DCACHE_stall=1 next state BUSY.
REQ-010 BUSY: request SHALL stay asserted with stable addr/wdata until a cycle with DCACHE_stall=0 (completion).
REQ-011 On completion with stall_in=1, SHALL capture DCACHE_rdata into an internal load register and enter HOLD; with stall_in=0 return to IDLE.
REQ-012 HOLD: DCACHE_ren/wen SHALL be 0 (no re-issue); leave to IDLE on first cycle stall_in=0.
REQ-013 mem_stall SHALL equal (DCACHE_ren|DCACHE_wen) & DCACHE_stall, combinational.
REQ-014 DCACHE_ren and DCACHE_wen SHALL never both be 1; memrd_in&memwr_in together SHALL be treated as read only.
REQ-015 Load data SHALL be DCACHE_rdata on a completing cycle, else the load register (HOLD).
REQ-016 Result select SHALL be: mem2reg_in ? load data : jump_in ? PC_step_in : alu_result_in.
REQ-017 fwd_mem_dat SHALL equal the REQ-016 selection with alu/PC only (not load data); fwd_mem_regwr SHALL be regwr_in & ~mem2reg_in.
REQ-018 MEM/WB registers SHALL load on rising clk when mem_stall=0 and stall_in=0, else hold.
REQ-019 Latency: cache hit SHALL reach wb_data one edge after request; miss of N stall cycles SHALL reach it N+1 edges after request.
REQ-020 Non-memory instruction SHALL pass in one cycle with no cache activity.

Reset
REQ-021 rst_n=0 at an edge SHALL set state IDLE, load register 0, wb_data/rd_out/regwr_out/mul_ppl_out 0.
REQ-022 While rst_n=0, DCACHE_ren, DCACHE_wen, mem_stall SHALL be 0, including reset during BUSY; the abandoned access is not resumed.

Configuration
REQ-023 Macro MEM_MISALIGN_CHECK_EN SHALL, when defined, add output misalign_err 1: a memory op with alu_result_in[1:0]!=0 suppresses ren/wen, completes in one cycle, forces regwr_out 0, and sets misalign_err sticky until reset.
REQ-024 Without MEM_MISALIGN_CHECK_EN, port misalign_err SHALL not exist and addr[1:0] SHALL be ignored.

Structure
REQ-025 FSM state typedef/localparams and the 30-bit cache address width SHALL live in the shared riscv package.
REQ-026 Sole sub-module SHALL be mem_fsm (state register, request and mem_stall logic); datapath stays in mem_stage.

Verification
REQ-027 Load hit: memrd_in=1, mem2reg_in=1, alu=0x100, rdata=0xDEADBEEF, DCACHE_stall=0 -> ren=1, addr=0x40, next edge wb_data=0xDEADBEEF, regwr_out=1.
REQ-028 Store miss 3 cycles: memwr_in=1, wdata=0x1234 -> wen=1 held 4 cycles, mem_stall=1 for 3, wb regs update on 4th edge, ren never 1.
REQ-029 Load completes during stall_in=1 for 2 cycles -> HOLD, no re-request, wb_data = captured rdata after stall_in drops even though DCACHE_rdata changed.
REQ-030 jal: jump_in=1, PC_step_in=0x204 -> wb_data=0x204 next edge, no cache access.
REQ-031 Reset asserted in BUSY -> ren/wen/mem_stall 0 that cycle; state IDLE, outputs 0 after edge.
REQ-032 With MEM_MISALIGN_CHECK_EN: lw at 0x102 -> no ren, regwr_out=0, misalign_err=1 held until rst_n=0.
